pe_out_packer: RTL and testbench
================================

Name: pe_out_packer

Overview:
- Output stage directly downstream of vectorized_PE.
- Captures the PE result bus together with its per-lane valid and tlast, and buffers the beats in a small FIFO.
- Re-emits the beats as a single AXI4-Stream master with a tkeep byte mask and real tready backpressure.
- The PE has no ready input, so this block raises o_almost_full to stall the PE feeder before the FIFO overflows.

Parameters:
- PHIT_SIZE, 512, data width in bits; must equal SIMD_DEGREE*32.
- SIMD_DEGREE, 16, number of fp32 lanes.
- DEPTH, 8, FIFO depth in beats; power of two, at least 4.
- AFULL_MARGIN, 2, free slots remaining when o_almost_full asserts; must be less than DEPTH.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- i_PE_result  in  PHIT_SIZE  PE output data (o_PE_typeC).
- i_tvalid_PE  in  SIMD_DEGREE  per-lane valid.
- i_tlast_PE  in  SIMD_DEGREE  per-lane last.
- m_axis_tdata  out  PHIT_SIZE  output beat.
- m_axis_tkeep  out  PHIT_SIZE/8  byte enables.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  end of packet.
- m_axis_tready  in  1  downstream ready.
- o_almost_full  out  1  stall request to the PE feeder.
- o_overflow  out  1  sticky flag: a beat was dropped.

Behaviour:
- Write condition: wr = |i_tvalid_PE.
- Stored data: lane k takes i_PE_result[32k+31:32k] when i_tvalid_PE[k] is 1, else 32'h0.
- Stored keep: the 4 tkeep bits of lane k equal i_tvalid_PE[k].
- Stored last: |(i_tvalid_PE & i_tlast_PE). A tlast on an invalid lane is ignored.
- FIFO storage: circular buffer with registered read and write pointers of log2(DEPTH) bits, plus a count register from 0 to DEPTH. Pointers wrap modulo DEPTH.
- Read occurs when m_axis_tvalid && m_axis_tready.
- m_axis_tvalid = (count != 0). The m_axis_* data outputs present the entry at the read pointer.
- Latency: a beat written in cycle N is visible on m_axis in cycle N+1. There is no same-cycle bypass when the FIFO is empty.
- Count update:
  - write only: +1.
  - read only: −1.
  - write and read in the same cycle: unchanged, and both pointers advance.
- Full FIFO (count == DEPTH) with wr:
  - If a read happens in the same cycle, the write is accepted.
  - Otherwise the beat is dropped, pointers and count stay unchanged, and o_overflow sets and holds until rst.
- Empty FIFO: m_axis_tvalid = 0. m_axis_tdata, tkeep and tlast still show the stale entry at the read pointer and must not be relied on.
- o_almost_full = (count >= DEPTH − AFULL_MARGIN). This is a combinational decode of the count register and is deasserted in the same cycle count drops below the threshold.
- AXI rule: once m_axis_tvalid is high, tdata, tkeep and tlast hold stable until the handshake completes.
- Reset (synchronous, active-high, including mid-packet):
  - Pointers and count return to 0.
  - m_axis_tvalid = 0, o_almost_full = 0, o_overflow = 0.
  - FIFO storage contents are not cleared.
  - Input beats arriving during the rst cycle are discarded.

Optional Feature:
- Macro: PE_OUT_PACKER_STATS_EN.
- When defined, the block adds these outputs:
  - o_beat_cnt (32 bits): counts accepted writes.
  - o_pkt_cnt (32 bits): counts read handshakes that carry tlast = 1.
  - o_drop_cnt (16 bits): counts dropped beats, saturating at 16'hFFFF.
- All three counters clear on rst. o_beat_cnt and o_pkt_cnt wrap at 2^32.
- When the macro is not defined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- ADD result: i_PE_result has lanes 0 and 1 = 32'h40c00000, i_tvalid_PE = 16'hFFFF, i_tlast_PE = 16'hFFFF, tready = 1.
  Required next cycle: m_axis_tvalid = 1, lanes 0 and 1 = 32'h40c00000, tkeep all 1s, tlast = 1, then tvalid = 0.
- Partial lanes: i_tvalid_PE = 16'h0003 with lane 2 = 32'h41000000.
  Required: tkeep = 64'h00FF, lane 2 of tdata = 0, tlast = 0 when i_tlast_PE = 16'h0004 (tlast on an invalid lane only).
- Backpressure: tready = 0 while writing the MACC results 41300000, 41900000, 427c0000 (last beat with tlast), with DEPTH = 8 and AFULL_MARGIN = 2.
  Required: count = 3, o_almost_full = 0. After 3 more writes o_almost_full = 1. After releasing tready, the beats come out in order and tlast appears only on the 427c0000 beat.
- Overflow: 9 consecutive writes with tready = 0.
  Required: the 9th beat is dropped, o_overflow = 1, and the 8 stored beats drain intact. With the stats macro, o_drop_cnt = 1.
- Simultaneous read and write at full: count = 8, wr = 1, tready = 1.
  Required: count stays 8, no drop, o_overflow stays 0.
- Reset mid-stream: assert rst for 1 cycle with 5 beats queued.
  Required: next cycle m_axis_tvalid = 0, o_almost_full = 0, o_overflow = 0. A beat written after rst is the first one to appear on m_axis.

Source files
------------

// File: rtl/pe_out_packer.sv
// Output stage after vectorized_PE: packs valid lanes into beats, queues them in a
// FIFO and presents an AXI4-Stream master. Define PE_OUT_PACKER_STATS_EN for counters.
module pe_out_packer #(
  parameter int unsigned PHIT_SIZE    = 512,
  parameter int unsigned SIMD_DEGREE  = 16,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PHIT_SIZE-1:0]   i_PE_result,
  input  logic [SIMD_DEGREE-1:0] i_tvalid_PE,
  input  logic [SIMD_DEGREE-1:0] i_tlast_PE,
  output logic [PHIT_SIZE-1:0]   m_axis_tdata,
  output logic [PHIT_SIZE/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic                   o_almost_full,
  output logic                   o_overflow
`ifdef PE_OUT_PACKER_STATS_EN
  ,
  output logic [31:0]            o_beat_cnt,
  output logic [31:0]            o_pkt_cnt,
  output logic [15:0]            o_drop_cnt
`endif
);

  localparam int unsigned KW = PHIT_SIZE / 8;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(DEPTH - AFULL_MARGIN);

  logic [PHIT_SIZE-1:0] data_mem [DEPTH];
  logic [KW-1:0]        keep_mem [DEPTH];
  logic                 last_mem [DEPTH];

  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;

  logic [PHIT_SIZE-1:0] beat_data;
  logic [KW-1:0]        beat_keep;
  logic                 beat_last;
  logic                 wr;
  logic                 rd;
  logic                 accept;
  logic                 drop;

  // Zero invalid lanes and expand lane valids into byte enables
  always_comb begin
    beat_data = '0;
    beat_keep = '0;
    for (int k = 0; k < SIMD_DEGREE; k++) begin
      if (i_tvalid_PE[k]) begin
        beat_data[32*k +: 32] = i_PE_result[32*k +: 32];
        beat_keep[4*k +: 4]   = 4'hF;
      end
    end
    beat_last = |(i_tvalid_PE & i_tlast_PE);
  end

  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign wr     = |i_tvalid_PE;
  assign rd     = m_axis_tvalid && m_axis_tready;
  assign accept = wr && ((count != FULL_CNT) || rd);
  assign drop   = wr && (count == FULL_CNT) && !rd;

  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = data_mem[rd_ptr];
  assign m_axis_tkeep  = keep_mem[rd_ptr];
  assign m_axis_tlast  = last_mem[rd_ptr];
  assign o_almost_full = (count >= AFULL_CNT);

  // Storage is deliberately left uncleared by reset
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      data_mem[wr_ptr] <= beat_data;
      keep_mem[wr_ptr] <= beat_keep;
      last_mem[wr_ptr] <= beat_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (rd)     rd_ptr <= rd_ptr + AW'(1);
      case ({accept, rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) o_overflow <= 1'b1;
    end
  end

`ifdef PE_OUT_PACKER_STATS_EN
  // Traffic counters; the drop counter saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      o_beat_cnt <= '0;
      o_pkt_cnt  <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (accept)              o_beat_cnt <= o_beat_cnt + 32'd1;
      if (rd && m_axis_tlast)  o_pkt_cnt  <= o_pkt_cnt + 32'd1;
      if (drop && (o_drop_cnt != 16'hFFFF)) o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_out_packer.sv
// Bench for pe_out_packer: table vectors, directed multi-cycle sequences and random
// traffic checked against a queue-based model of the FIFO.
module tb_pe_out_packer;

  localparam int unsigned PHIT  = 512;
  localparam int unsigned SIMD  = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AFM   = 2;

  logic             clk;
  logic             rst;
  logic [PHIT-1:0]  i_PE_result;
  logic [SIMD-1:0]  i_tvalid_PE;
  logic [SIMD-1:0]  i_tlast_PE;
  logic [PHIT-1:0]  m_axis_tdata;
  logic [PHIT/8-1:0] m_axis_tkeep;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tready;
  logic             o_almost_full;
  logic             o_overflow;
`ifdef PE_OUT_PACKER_STATS_EN
  logic [31:0]      o_beat_cnt;
  logic [31:0]      o_pkt_cnt;
  logic [15:0]      o_drop_cnt;
`endif

  pe_out_packer #(.PHIT_SIZE(PHIT), .SIMD_DEGREE(SIMD), .DEPTH(DEPTH), .AFULL_MARGIN(AFM)) dut (
    .clk(clk), .rst(rst),
    .i_PE_result(i_PE_result), .i_tvalid_PE(i_tvalid_PE), .i_tlast_PE(i_tlast_PE),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .o_almost_full(o_almost_full), .o_overflow(o_overflow)
`ifdef PE_OUT_PACKER_STATS_EN
    , .o_beat_cnt(o_beat_cnt), .o_pkt_cnt(o_pkt_cnt), .o_drop_cnt(o_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PHIT-1:0]   d;
    logic [PHIT/8-1:0] k;
    logic              l;
  } beat_t;

  typedef struct {
    logic [PHIT-1:0]   res;
    logic [SIMD-1:0]   v;
    logic [SIMD-1:0]   l;
    logic [PHIT-1:0]   exp_data;
    logic [PHIT/8-1:0] exp_keep;
    logic              exp_last;
  } vec_t;

  beat_t       q[$];
  logic        m_ovf;
  int unsigned m_beats, m_pkts, m_drops;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [PHIT-1:0] act, input logic [PHIT-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    check("tvalid", PHIT'(m_axis_tvalid), PHIT'(q.size() != 0));
    check("almost_full", PHIT'(o_almost_full), PHIT'(q.size() >= DEPTH - AFM));
    check("overflow", PHIT'(o_overflow), PHIT'(m_ovf));
    if (q.size() != 0) begin
      check("tdata", m_axis_tdata, q[0].d);
      check("tkeep", PHIT'(m_axis_tkeep), PHIT'(q[0].k));
      check("tlast", PHIT'(m_axis_tlast), PHIT'(q[0].l));
    end
`ifdef PE_OUT_PACKER_STATS_EN
    check("beat_cnt", PHIT'(o_beat_cnt), PHIT'(m_beats));
    check("pkt_cnt", PHIT'(o_pkt_cnt), PHIT'(m_pkts));
    check("drop_cnt", PHIT'(o_drop_cnt), PHIT'(m_drops));
`endif
  endtask

  // One clock: drive inputs, advance the model, compare after the edge
  task automatic cyc(input logic [PHIT-1:0] pe, input logic [SIMD-1:0] v,
                     input logic [SIMD-1:0] l, input logic rdy);
    beat_t b;
    int    pre;
    logic  rd_m;
    i_PE_result   = pe;
    i_tvalid_PE   = v;
    i_tlast_PE    = l;
    m_axis_tready = rdy;
    b.d = '0;
    b.k = '0;
    for (int k = 0; k < SIMD; k++) begin
      if (v[k]) begin
        b.d[32*k +: 32] = pe[32*k +: 32];
        b.k[4*k +: 4]   = 4'hF;
      end
    end
    b.l  = (v & l) != '0;
    pre  = q.size();
    rd_m = (pre != 0) && rdy;
    if (rd_m) begin
      if (q[0].l) m_pkts++;
      q.delete(0);
    end
    if (v != '0) begin
      if (pre < DEPTH || rd_m) begin
        q.push_back(b);
        m_beats++;
      end else begin
        m_ovf = 1'b1;
        if (m_drops != 16'hFFFF) m_drops++;
      end
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  // Reset with a live beat on the inputs, which must be discarded
  task automatic rst_cycle();
    rst           = 1'b1;
    i_PE_result   = {16{32'h12345678}};
    i_tvalid_PE   = '1;
    i_tlast_PE    = '1;
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_ovf   = 1'b0;
    m_beats = 0;
    m_pkts  = 0;
    m_drops = 0;
    check_model();
  endtask

  function automatic logic [PHIT-1:0] lane0(input logic [31:0] x);
    return {480'h0, x};
  endfunction

  function automatic logic [PHIT-1:0] rand_bus();
    logic [PHIT-1:0] r;
    for (int k = 0; k < SIMD; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  vec_t        vecs[4];
  logic [31:0] bp_vals[6];
  logic        bp_last[6];

  initial begin
    rst = 1'b1;
    i_PE_result = '0;
    i_tvalid_PE = '0;
    i_tlast_PE  = '0;
    m_axis_tready = 1'b0;
    m_ovf = 1'b0;
    m_beats = 0;
    m_pkts = 0;
    m_drops = 0;

    vecs[0] = '{{448'h0, 32'h40c00000, 32'h40c00000}, 16'hFFFF, 16'hFFFF,
                {448'h0, 32'h40c00000, 32'h40c00000}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[1] = '{{416'h0, 32'h41000000, 32'h40000000, 32'h3f800000}, 16'h0003, 16'h0004,
                {448'h0, 32'h40000000, 32'h3f800000}, 64'h0000_0000_0000_00FF, 1'b0};
    vecs[2] = '{{16{32'h3f800000}}, 16'h8001, 16'h8000,
                {32'h3f800000, 448'h0, 32'h3f800000}, 64'hF000_0000_0000_000F, 1'b1};
    vecs[3] = '{{16{32'hC0490FDB}}, 16'h0F00, 16'h00FF,
                {128'h0, {4{32'hC0490FDB}}, 256'h0}, 64'h0000_FFFF_0000_0000, 1'b0};

    rst_cycle();
    check("reset_tvalid", PHIT'(m_axis_tvalid), PHIT'(1'b0));

    // Table vectors: one beat in, visible next cycle, gone after the handshake
    for (int i = 0; i < 4; i++) begin
      cyc(vecs[i].res, vecs[i].v, vecs[i].l, 1'b1);
      check("vec_tvalid", PHIT'(m_axis_tvalid), PHIT'(1'b1));
      check("vec_tdata", m_axis_tdata, vecs[i].exp_data);
      check("vec_tkeep", PHIT'(m_axis_tkeep), PHIT'(vecs[i].exp_keep));
      check("vec_tlast", PHIT'(m_axis_tlast), PHIT'(vecs[i].exp_last));
      cyc('0, '0, '0, 1'b1);
      check("vec_drained", PHIT'(m_axis_tvalid), PHIT'(1'b0));
    end

    // Backpressure and almost-full threshold
    bp_vals = '{32'h41300000, 32'h41900000, 32'h427c0000, 32'h11, 32'h22, 32'h33};
    bp_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    rst_cycle();
    for (int i = 0; i < 3; i++) cyc(lane0(bp_vals[i]), 16'h0001, bp_last[i] ? 16'h0001 : 16'h0, 1'b0);
    check("bp_afull_3", PHIT'(o_almost_full), PHIT'(1'b0));
    for (int i = 3; i < 6; i++) cyc(lane0(bp_vals[i]), 16'h0001, 16'h0, 1'b0);
    check("bp_afull_6", PHIT'(o_almost_full), PHIT'(1'b1));
    for (int i = 0; i < 6; i++) begin
      check("bp_order", m_axis_tdata, lane0(bp_vals[i]));
      check("bp_tlast", PHIT'(m_axis_tlast), PHIT'(bp_last[i]));
      cyc('0, '0, '0, 1'b1);
    end
    check("bp_empty", PHIT'(m_axis_tvalid), PHIT'(1'b0));

    // Overflow: ninth write with no reader is dropped
    rst_cycle();
    for (int i = 0; i < 9; i++) cyc(lane0(32'(i + 1)), 16'h0001, 16'h0, 1'b0);
    check("ovf_flag", PHIT'(o_overflow), PHIT'(1'b1));
`ifdef PE_OUT_PACKER_STATS_EN
    check("ovf_drop_cnt", PHIT'(o_drop_cnt), PHIT'(16'd1));
`endif
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain", m_axis_tdata, lane0(32'(i + 1)));
      cyc('0, '0, '0, 1'b1);
    end
    check("ovf_empty", PHIT'(m_axis_tvalid), PHIT'(1'b0));
    check("ovf_sticky", PHIT'(o_overflow), PHIT'(1'b1));

    // Simultaneous read and write while full
    rst_cycle();
    for (int i = 0; i < 8; i++) cyc(lane0(32'(i + 1)), 16'h0001, 16'h0, 1'b0);
    cyc(lane0(32'h99), 16'h0001, 16'h0, 1'b1);
    check("rw_full_ovf", PHIT'(o_overflow), PHIT'(1'b0));
    check("rw_full_afull", PHIT'(o_almost_full), PHIT'(1'b1));
    check("rw_full_head", m_axis_tdata, lane0(32'h2));
    cyc(lane0(32'hAA), 16'h0001, 16'h0, 1'b0);
    check("rw_full_still_full", PHIT'(o_overflow), PHIT'(1'b1));

    // Reset mid-stream
    rst_cycle();
    for (int i = 0; i < 5; i++) cyc(lane0(32'(i + 100)), 16'h0001, 16'h0, 1'b0);
    rst_cycle();
    check("mid_rst_tvalid", PHIT'(m_axis_tvalid), PHIT'(1'b0));
    check("mid_rst_afull", PHIT'(o_almost_full), PHIT'(1'b0));
    check("mid_rst_ovf", PHIT'(o_overflow), PHIT'(1'b0));
    cyc(lane0(32'hABCD), 16'h0001, 16'h0, 1'b0);
    check("post_rst_first", m_axis_tdata, lane0(32'hABCD));
    cyc('0, '0, '0, 1'b1);
    check("post_rst_only", PHIT'(m_axis_tvalid), PHIT'(1'b0));

    // Random traffic: low-ready phase stresses full/overflow, then a faster drain phase
    for (int n = 0; n < 3000; n++) begin
      logic [SIMD-1:0] v;
      logic            rdy;
      if ($urandom_range(0, 599) == 0) rst_cycle();
      v   = ($urandom_range(0, 3) == 0) ? '0 : SIMD'($urandom);
      rdy = (n < 1200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cyc(rand_bus(), v, SIMD'($urandom), rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
